// File: rtl/ped_pkg.sv
// ped_pkg: state encoding and timing defaults shared by the button conditioner and the crossing FSM
package ped_pkg;
  localparam logic [1:0] RELEASED = 2'b00;
  localparam logic [1:0] PRESS_WAIT = 2'b01;
  localparam logic [1:0] PRESSED = 2'b10;
  localparam logic [1:0] RELEASE_WAIT = 2'b11;
  localparam int DB_CYCLES_DEFAULT = 1000000;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous level input
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or posedge reset)
    if (reset) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: debounces the pedestrian button and latches a crossing request until acked
module button_conditioner
  import ped_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int CNT_W = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button_raw,
  input  logic       enable,
  input  logic       ack,
  output logic       button_level,
  output logic       press_pulse,
  output logic       req,
  output logic [7:0] press_count
);
  logic s, last, rise;
  logic [1:0] state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  sync_2ff u_sync (.clk(clk), .reset(reset), .d(button_raw), .q(s));
  assign last = cnt == CNT_W'(DB_CYCLES - 1);
  // state[1] is the debounced level; state[0] marks a pending change being timed
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    if (s == state[1]) begin
      state_nxt = state[1] ? PRESSED : RELEASED;
      cnt_nxt = '0;
    end else if (!state[0]) begin
      state_nxt = state[1] ? RELEASE_WAIT : PRESS_WAIT;
      cnt_nxt = CNT_W'(1);
    end else if (last) begin
      state_nxt = state[1] ? RELEASED : PRESSED;
      cnt_nxt = '0;
    end else begin
      cnt_nxt = cnt + 1'b1;
    end
  end
  assign rise = state == PRESS_WAIT && state_nxt == PRESSED;
  assign button_level = state[1];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= RELEASED;
      cnt <= '0;
      press_pulse <= 1'b0;
      req <= 1'b0;
      press_count <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      press_pulse <= rise;
      req <= (press_pulse && enable) || (req && !ack);
      if (rise && press_count != 8'hFF) press_count <= press_count + 8'd1;
    end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed tables, corner sequences and randomized presses against a run-length model
module tb_button_conditioner;
  localparam int DB = 4;
  logic clk = 1'b0, reset = 1'b1, button_raw = 1'b0, enable = 1'b1, ack = 1'b0;
  logic button_level, press_pulse, req;
  logic [7:0] press_count;
  int tests = 0, fails = 0;

  button_conditioner #(.DB_CYCLES(DB), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .button_raw(button_raw), .enable(enable), .ack(ack),
    .button_level(button_level), .press_pulse(press_pulse), .req(req), .press_count(press_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic a);
    @(negedge clk);
    button_raw = r;
    enable = e;
    ack = a;
    @(posedge clk);
    #2;
  endtask

  // Model: the block sees the raw input two samples late; the level flips after DB consecutive
  // samples disagreeing with it, and only a 0->1 flip counts as a press.
  bit sy1, sy2, m_level, m_pulse, m_req;
  int run, m_count;
  always @(posedge clk) begin
    bit s, p;
    if (reset) begin
      sy1 = 0; sy2 = 0; m_level = 0; m_pulse = 0; m_req = 0; run = 0; m_count = 0;
    end else begin
      s = sy2;
      sy2 = sy1;
      sy1 = button_raw;
      m_req = (m_pulse && enable) ? 1'b1 : ack ? 1'b0 : m_req;
      p = 0;
      if (s != m_level) begin
        run++;
        if (run == DB) begin
          m_level = s;
          run = 0;
          p = s;
        end
      end else run = 0;
      m_pulse = p;
      if (p && m_count < 255) m_count++;
    end
    #1;
    chk("model_level", int'(button_level), int'(m_level));
    chk("model_pulse", int'(press_pulse), int'(m_pulse));
    chk("model_req", int'(req), int'(m_req));
    chk("model_count", int'(press_count), m_count);
  end

  typedef struct {
    logic raw; logic en; logic a;
    logic lvl; logic pul; logic rq; int cnt;
  } vec_t;
  vec_t tbl[10];

  initial begin
    int np, at, base;
    // clean press, one row per edge starting with the first edge that samples raw high
    for (int j = 0; j < 10; j++)
      tbl[j] = '{raw: 1'b1, en: 1'b1, a: 1'b0, lvl: (j >= 5), pul: (j == 5), rq: (j >= 6), cnt: (j >= 5) ? 1 : 0};

    repeat (3) @(posedge clk);
    #2;
    chk("reset_level", int'(button_level), 0);
    chk("reset_pulse", int'(press_pulse), 0);
    chk("reset_req", int'(req), 0);
    chk("reset_count", int'(press_count), 0);
    @(negedge clk) reset = 1'b0;
    repeat (4) step(1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].raw, tbl[i].en, tbl[i].a);
      chk($sformatf("tbl%0d_level", i), int'(button_level), int'(tbl[i].lvl));
      chk($sformatf("tbl%0d_pulse", i), int'(press_pulse), int'(tbl[i].pul));
      chk($sformatf("tbl%0d_req", i), int'(req), int'(tbl[i].rq));
      chk($sformatf("tbl%0d_count", i), int'(press_count), tbl[i].cnt);
    end

    // bounce 1,0,1,0 then held high: one pulse, 5 edges after the final rising sample
    repeat (8) step(1'b0, 1'b1, 1'b0);
    np = 0;
    at = -1;
    for (int i = 0; i < 16; i++) begin
      step((i < 4) ? ((i % 2) == 0) : 1'b1, 1'b1, 1'b0);
      if (press_pulse) begin np++; at = i; end
    end
    chk("bounce_pulses", np, 1);
    chk("bounce_pulse_edge", at, 9);

    // ack coincident with a new press keeps req; a later ack clears it
    repeat (8) step(1'b0, 1'b1, 1'b0);
    chk("collide_req_before", int'(req), 1);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, (i == 6 || i == 9));
      if (i == 5) chk("collide_pulse", int'(press_pulse), 1);
      if (i == 6) chk("collide_req_kept", int'(req), 1);
      if (i == 9) chk("late_ack_req", int'(req), 0);
    end

    // press with enable low counts but does not request
    repeat (8) step(1'b0, 1'b0, 1'b0);
    base = int'(press_count);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (i == 5) chk("en0_pulse", int'(press_pulse), 1);
    end
    chk("en0_req", int'(req), 0);
    chk("en0_count", int'(press_count), base + 1);
    repeat (8) step(1'b0, 1'b1, 1'b0);
    repeat (8) step(1'b1, 1'b1, 1'b0);
    chk("en1_req_set", int'(req), 1);
    repeat (8) step(1'b0, 1'b0, 1'b0);
    repeat (8) step(1'b1, 1'b0, 1'b0);
    chk("en0_req_held", int'(req), 1);

    // reset mid-debounce with the button held: progress discarded, re-debounced once
    repeat (8) step(1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b0);
    @(negedge clk) reset = 1'b1;
    #1;
    chk("async_rst_level", int'(button_level), 0);
    chk("async_rst_pulse", int'(press_pulse), 0);
    chk("async_rst_req", int'(req), 0);
    chk("async_rst_count", int'(press_count), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    np = 0;
    at = -1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #2;
      if (press_pulse) begin np++; at = i; end
    end
    chk("post_rst_pulses", np, 1);
    chk("post_rst_pulse_edge", at, 5);
    chk("post_rst_count", int'(press_count), 1);

    // randomized bouncy presses with random enable/ack, enough to saturate the counter
    for (int k = 0; k < 300; k++) begin
      int nb;
      nb = $urandom_range(0, 3);
      for (int b = 0; b < nb; b++) step(1'(b % 2 == 0), ($urandom % 4) != 0, ($urandom % 8) == 0);
      repeat ($urandom_range(4, 9)) step(1'b1, ($urandom % 4) != 0, ($urandom % 8) == 0);
      repeat ($urandom_range(4, 9)) step(1'b0, ($urandom % 4) != 0, ($urandom % 8) == 0);
    end
    chk("saturated_count", int'(press_count), 255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 1000000, giving the debounce stability window in clk cycles; legal range 2..2^CNT_W-1.
REQ-002 The block SHALL have parameter CNT_W, default 20, giving the debounce counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock, all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port button_raw, input, 1 bit: asynchronous, bouncy pedestrian push-button, high = pressed.
REQ-006 The block SHALL have port enable, input, 1 bit: high = presses may raise a request; low during the crossing FSM's relaxing period.
REQ-007 The block SHALL have port ack, input, 1 bit: one-cycle pulse from the crossing FSM when it accepts the request.
REQ-008 The block SHALL have port button_level, output, 1 bit: debounced button level.
REQ-009 The block SHALL have port press_pulse, output, 1 bit: single-cycle strobe per debounced press.
REQ-010 The block SHALL have port req, output, 1 bit: latched crossing request, held until acked.
REQ-011 The block SHALL have port press_count, output, 8 bits: saturating count of debounced presses, for diagnostics.

Function
REQ-012 button_raw SHALL pass through a two-flop synchronizer; its output s is the only signal the block uses.
REQ-013 The FSM SHALL have states RELEASED, PRESS_WAIT, PRESSED and RELEASE_WAIT.
REQ-014 In RELEASED with s=1, the FSM SHALL go to PRESS_WAIT with cnt<=1; otherwise it stays.
REQ-015 In PRESS_WAIT with s=0, the FSM SHALL return to RELEASED and clear cnt (a bounce discards the attempt).
REQ-016 In PRESS_WAIT with s=1 and cnt==DB_CYCLES-1, the FSM SHALL go to PRESSED; with s=1 and a lower cnt, it increments cnt.
REQ-017 PRESSED to RELEASE_WAIT to RELEASED SHALL mirror REQ-014..016 with s=0 as the stable level; s=1 in RELEASE_WAIT returns to PRESSED.
REQ-018 button_level SHALL be 1 exactly while the state is PRESSED or RELEASE_WAIT.
REQ-019 press_pulse SHALL be registered and high for exactly one cycle: the cycle after the PRESS_WAIT->PRESSED edge. Release produces no pulse.
REQ-020 With button_raw first sampled high at edge N and held steady, press_pulse SHALL be high in the cycle following edge N+1+DB_CYCLES.
REQ-021 req SHALL be set on press_pulse when enable=1 and cleared on ack.
REQ-022 press_pulse and ack in the same cycle SHALL leave req=1: a new press wins.
REQ-023 A press while req=1 SHALL NOT be queued; req stays 1.
REQ-024 A press while enable=0 SHALL NOT set req; enable=0 SHALL NOT clear an already-set req.
REQ-025 ack while req=0 SHALL have no effect.
REQ-026 press_count SHALL increment on every press_pulse regardless of enable, and saturate at 255 with no wrap.

Reset
REQ-027 While reset is high: synchronizer flops=0, state=RELEASED, cnt=0, button_level=0, press_pulse=0, req=0, press_count=0.
REQ-028 Reset asserted mid-debounce or while PRESSED SHALL discard all progress; a button still held at release of reset SHALL be re-debounced from scratch and produce exactly one press_pulse.

Structure
REQ-029 Package ped_pkg SHALL hold the 2-bit state encoding constants and the default DB_CYCLES value, shared with the crossing FSM.
REQ-030 The synchronizer SHALL be the sub-module sync_2ff, with async-reset-to-0 flops.
REQ-031 The block SHALL contain no other sub-modules and no combinational path from any input to any output.

Verification (bench uses DB_CYCLES=4)
REQ-032 Clean press: raw high at edge 10, held 20 cycles -> press_pulse high for one cycle after edge 15; button_level=1; req=1; press_count=1.
REQ-033 Bounce: raw toggles 1,0,1,0 on successive cycles, then held high -> no pulse during the bounce; exactly one pulse 5 edges after the final rising sample.
REQ-034 Ack collision: req=1, ack coincident with a second press_pulse -> req stays 1; an ack 3 cycles later -> req=0.
REQ-035 enable=0 press -> press_pulse and press_count increment, req stays 0; req already set stays set through enable=0.
REQ-036 Reset mid-PRESS_WAIT with raw held high -> all outputs 0; exactly one pulse 5 edges after reset deasserts.
REQ-037 300 presses -> press_count=255, no wrap.
